// File: rtl/bp_fe_pc_sel_sched_if.sv
// ----------------------------------------------------------------------------
// bp_fe_pc_sel_sched_if
//   Bundles every non-clock/reset signal of the next-PC scheduler.
//   Signal names keep the scheduler's point of view: *_i are driven into the
//   scheduler, *_o are driven by it.
//
//   master : the fetch-pipeline side (icache/itlb/BTB/RAS/backend), drives *_i
//   slave  : the scheduler itself, drives *_o
//
//   fetch_ready_i     icache, itlb and fe queue can all accept a PC
//   redirect_v_i/pc_i backend redirect request, redirect_ready_o accepts it
//   icache_miss_i     icache miss level (held until refill done)
//   tlb_miss_i        itlb miss level
//   pc_f1_i, pc_f2_i  PCs currently in f1 / f2
//   ras_*, btb_*, br_* prediction sources (valid + target)
//   pc_n_o/pc_n_v_o   next fetch PC and its valid
//   pc_src_o          selected source code
//   ras_pop_o         RAS pop pulse
//   flush_o           squash f1/f2
//   misalign_o        accepted redirect target was not 4-byte aligned
// ----------------------------------------------------------------------------
interface bp_fe_pc_sel_sched_if #(
  parameter int eaddr_width_p = 64
);

  logic                     fetch_ready_i;
  logic                     redirect_v_i;
  logic [eaddr_width_p-1:0] redirect_pc_i;
  logic                     redirect_ready_o;
  logic                     icache_miss_i;
  logic                     tlb_miss_i;
  logic [eaddr_width_p-1:0] pc_f1_i;
  logic [eaddr_width_p-1:0] pc_f2_i;
  logic                     ras_v_i;
  logic [eaddr_width_p-1:0] ras_pc_i;
  logic                     btb_v_i;
  logic [eaddr_width_p-1:0] btb_pc_i;
  logic                     br_v_i;
  logic [eaddr_width_p-1:0] br_pc_i;
  logic [eaddr_width_p-1:0] pc_n_o;
  logic                     pc_n_v_o;
  logic [2:0]               pc_src_o;
  logic                     ras_pop_o;
  logic                     flush_o;
  logic                     misalign_o;

  modport master (
    output fetch_ready_i, redirect_v_i, redirect_pc_i,
           icache_miss_i, tlb_miss_i, pc_f1_i, pc_f2_i,
           ras_v_i, ras_pc_i, btb_v_i, btb_pc_i, br_v_i, br_pc_i,
    input  redirect_ready_o, pc_n_o, pc_n_v_o, pc_src_o,
           ras_pop_o, flush_o, misalign_o
  );

  modport slave (
    input  fetch_ready_i, redirect_v_i, redirect_pc_i,
           icache_miss_i, tlb_miss_i, pc_f1_i, pc_f2_i,
           ras_v_i, ras_pc_i, btb_v_i, btb_pc_i, br_v_i, br_pc_i,
    output redirect_ready_o, pc_n_o, pc_n_v_o, pc_src_o,
           ras_pop_o, flush_o, misalign_o
  );

endinterface

// File: rtl/bp_fe_pc_sel_sched.sv
// ----------------------------------------------------------------------------
// bp_fe_pc_sel_sched
//   Next-PC scheduler for the frontend fetch pipeline. Every cycle it picks
//   one source for the next fetch PC: backend redirect, miss replay, RAS,
//   BTB, static branch/jal or sequential (pc_f1 + 4). A small FSM sequences
//   boot, icache/itlb miss waits and the replay of the missing PC.
//
//   Ports
//     clk_i      clock
//     reset_n_i  asynchronous reset, active low
//     fe         bp_fe_pc_sel_sched_if.slave, all fetch-side signals
//
//   pc_n_o and the other outputs are combinational from the inputs and the
//   registered state (zero-cycle latency); state, RAS holdoff and the replay
//   PC update on the rising clock edge.
// ----------------------------------------------------------------------------
module bp_fe_pc_sel_sched #(
  parameter int                       eaddr_width_p = 64,
  parameter logic [eaddr_width_p-1:0] first_pc_p    = eaddr_width_p'('h8000_0000),
  parameter int                       ras_holdoff_p = 2
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  bp_fe_pc_sel_sched_if.slave        fe
);

  localparam int hold_w_lp = (ras_holdoff_p < 1) ? 1 : $clog2(ras_holdoff_p + 1);

  typedef enum logic [2:0] {
    e_boot,
    e_run,
    e_imiss,
    e_tmiss,
    e_replay
  } state_e;

  typedef enum logic [2:0] {
    e_src_seq      = 3'd0,
    e_src_br       = 3'd1,
    e_src_btb      = 3'd2,
    e_src_ras      = 3'd3,
    e_src_redirect = 3'd4,
    e_src_replay   = 3'd5,
    e_src_boot     = 3'd6
  } pc_src_e;

  state_e                   state_q,   state_d;
  logic [hold_w_lp-1:0]     holdoff_q, holdoff_d;
  logic [eaddr_width_p-1:0] replay_q,  replay_d;

  logic [eaddr_width_p-1:0] pc_n;
  logic                     pc_n_v;
  pc_src_e                  pc_src;
  logic                     redirect_ready;
  logic                     ras_pop;
  logic                     flush;
  logic                     misalign;

  logic                     in_miss;
  logic                     pred_ok;

  assign in_miss = (state_q == e_imiss) || (state_q == e_tmiss);
  // Predictions are ignored while a recent RAS pop is still settling.
  assign pred_ok = (holdoff_q == '0);

  // --------------------------------------------------------------------------
  // Next-PC selection and next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned in this block gets a default first so no
    // path through the case/if tree can leave it unassigned and infer a latch.
    pc_n           = first_pc_p;
    pc_n_v         = 1'b0;
    pc_src         = e_src_boot;
    redirect_ready = 1'b0;
    ras_pop        = 1'b0;
    flush          = 1'b0;
    misalign       = 1'b0;
    state_d        = state_q;
    holdoff_d      = holdoff_q;
    replay_d       = replay_q;

    unique case (state_q)
      e_boot: begin
        pc_n   = first_pc_p;
        pc_n_v = 1'b1;
        pc_src = e_src_boot;
        if (fe.fetch_ready_i) state_d = e_run;
      end

      e_run: begin
        pc_n_v = 1'b1;
        if (fe.ras_v_i && pred_ok) begin
          pc_n    = fe.ras_pc_i;
          pc_src  = e_src_ras;
          ras_pop = fe.fetch_ready_i;
        end else if (fe.btb_v_i && pred_ok) begin
          pc_n   = fe.btb_pc_i;
          pc_src = e_src_btb;
        end else if (fe.br_v_i && pred_ok) begin
          pc_n   = fe.br_pc_i;
          pc_src = e_src_br;
        end else begin
          // Sequential fetch wraps at the top of the address space.
          pc_n   = fe.pc_f1_i + eaddr_width_p'(4);
          pc_src = e_src_seq;
        end

        // Holdoff only moves on cycles where the fetch actually advances.
        if (fe.fetch_ready_i) begin
          if (ras_pop) begin
            holdoff_d = hold_w_lp'(ras_holdoff_p);
          end else if (holdoff_q != '0) begin
            holdoff_d = holdoff_q - hold_w_lp'(1);
          end
        end

        // icache miss belongs to the older (f2) instruction, so it wins.
        if (fe.icache_miss_i) begin
          replay_d = fe.pc_f2_i;
          state_d  = e_imiss;
        end else if (fe.tlb_miss_i) begin
          replay_d = fe.pc_f1_i;
          state_d  = e_tmiss;
        end
      end

      e_imiss: begin
        pc_n   = replay_q;
        pc_src = e_src_replay;
        if (!fe.icache_miss_i) state_d = e_replay;
      end

      e_tmiss: begin
        pc_n   = replay_q;
        pc_src = e_src_replay;
        if (!fe.tlb_miss_i) state_d = e_replay;
      end

      e_replay: begin
        pc_n   = replay_q;
        pc_n_v = 1'b1;
        pc_src = e_src_replay;
        if (fe.icache_miss_i) begin
          replay_d = fe.pc_f2_i;
          state_d  = e_imiss;
        end else if (fe.tlb_miss_i) begin
          replay_d = fe.pc_f1_i;
          state_d  = e_tmiss;
        end else if (fe.fetch_ready_i) begin
          state_d = e_run;
        end
      end

      default: begin
        state_d = e_boot;
      end
    endcase

    // A backend redirect overrides every other source and event. During a
    // miss wait the fetch path is idle, so the redirect needs no fetch_ready.
    if (state_q != e_boot) begin
      redirect_ready = fe.redirect_v_i && (fe.fetch_ready_i || in_miss);
    end

    if (redirect_ready) begin
      pc_n      = {fe.redirect_pc_i[eaddr_width_p-1:2], 2'b00};
      pc_n_v    = 1'b1;
      pc_src    = e_src_redirect;
      flush     = 1'b1;
      ras_pop   = 1'b0;
      misalign  = |fe.redirect_pc_i[1:0];
      holdoff_d = '0;
      replay_d  = replay_q;
      state_d   = e_run;
    end

    // While reset is held the outputs show boot values immediately, without
    // waiting for a clock edge, and never emit a pop or flush.
    if (!reset_n_i) begin
      pc_n           = first_pc_p;
      pc_n_v         = 1'b0;
      pc_src         = e_src_boot;
      redirect_ready = 1'b0;
      ras_pop        = 1'b0;
      flush          = 1'b0;
      misalign       = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      // NOTE: replay_q is an ordinary register, not a memory, so it is reset
      // along with the rest of the state to keep its value defined.
      state_q   <= e_boot;
      holdoff_q <= '0;
      replay_q  <= '0;
    end else begin
      state_q   <= state_d;
      holdoff_q <= holdoff_d;
      replay_q  <= replay_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign fe.pc_n_o           = pc_n;
  assign fe.pc_n_v_o         = pc_n_v;
  assign fe.pc_src_o         = pc_src;
  assign fe.redirect_ready_o = redirect_ready;
  assign fe.ras_pop_o        = ras_pop;
  assign fe.flush_o          = flush;
  assign fe.misalign_o       = misalign;

endmodule
